// File: rtl/axi_dwa_pkg.sv
// Shared definitions for the wide-side write-response path: B-channel
// response codes, merged-response field offsets and the EXOKAY mapping.
`timescale 1ns/1ps
package axi_dwa_pkg;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

    // Field offsets inside the merged response word (shared with the merger).
    localparam int RESP_ID_MSB    = 7;
    localparam int RESP_ID_LSB    = 5;
    localparam int RESP_CNT_MSB   = 4;
    localparam int RESP_CNT_LSB   = 2;
    localparam int RESP_BRESP_MSB = 1;
    localparam int RESP_BRESP_LSB = 0;

    // Exclusive-okay is reported as a plain okay; every other code is untouched.
    function automatic logic [1:0] map_exokay(input logic [1:0] code);
        logic [1:0] result;
        result = code;
        if (code == BRESP_EXOKAY) begin
            result = BRESP_OKAY;
        end
        return result;
    endfunction

endpackage

// File: rtl/b_resp_return_if.sv
// Merger-to-return and B-channel signal bundle.
// slave  : the response-return block (sources the B channel).
// master : the merger plus the wide-side AXI master (consumes the B channel).
`timescale 1ns/1ps
interface b_resp_return_if #(
    parameter int BID_WIDTH      = 3,
    parameter int BRESP_WIDTH    = 2,
    parameter int RESP_ARR_WIDTH = 9
);
    logic                      resp_valid;
    logic [RESP_ARR_WIDTH-1:0] resp;
    logic                      m_bvalid;
    logic                      m_bready;
    logic [BID_WIDTH-1:0]      m_bid;
    logic [BRESP_WIDTH-1:0]    m_bresp;

    modport slave (
        input  resp_valid,
        input  resp,
        input  m_bready,
        output m_bvalid,
        output m_bid,
        output m_bresp
    );

    modport master (
        output resp_valid,
        output resp,
        output m_bready,
        input  m_bvalid,
        input  m_bid,
        input  m_bresp
    );
endinterface

// File: rtl/b_resp_fifo.sv
// Show-ahead synchronous FIFO. The head entry is visible on pop_data as soon
// as it is written, so the consumer can present it without an extra register.
// Pointers carry one extra wrap bit to tell full from empty.
// DEPTH must be a power of two and at least 2.
`timescale 1ns/1ps
module b_resp_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                     aclk,
    input  logic                     arst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      wr_ptr_next;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      rd_ptr_next;
    logic             push_en;
    logic             pop_en;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign push_en = push && (!full || pop);
    assign pop_en  = pop && !empty;

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    // Next-pointer computation; wrap comes from natural modulo arithmetic.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push_en) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO without touching the array.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge aclk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/b_resp_return.sv
// Buffers merged write responses and returns them on the B channel.
// The merger cannot be stalled, so master back-pressure is absorbed by the
// FIFO; a response arriving while the FIFO is full and not draining is
// dropped and recorded in the sticky overflow flag and the drop counter.
`timescale 1ns/1ps
module b_resp_return
    import axi_dwa_pkg::*;
#(
    parameter int BID_WIDTH      = 3,
    parameter int BRESP_WIDTH    = 2,
    parameter int RESP_ARR_WIDTH = 9,
    parameter int DEPTH          = 8,
    parameter bit EXOKAY_PASS    = 1'b0
) (
    input  logic                   aclk,
    input  logic                   arst_n,
    b_resp_return_if.slave         bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);
    localparam int ENTRY_W = BID_WIDTH + BRESP_WIDTH;

    logic [BID_WIDTH-1:0]   push_id;
    logic [BRESP_WIDTH-1:0] push_bresp;
    logic [ENTRY_W-1:0]     push_data;
    logic [ENTRY_W-1:0]     head_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   b_valid;
    logic                   b_pop;
    logic                   drop;
    logic                   overflow_reg;
    logic [7:0]             drop_cnt_reg;
    logic                   unused_resp_bits;

    // The sub-transaction count and the top bit are not needed past the merger.
    assign unused_resp_bits = ^{bus.resp[RESP_ARR_WIDTH-1], bus.resp[RESP_CNT_MSB:RESP_CNT_LSB]};

    assign push_id = bus.resp[RESP_ID_MSB:RESP_ID_LSB];

    generate
        if (EXOKAY_PASS) begin : g_exokay_pass
            assign push_bresp = bus.resp[RESP_BRESP_MSB:RESP_BRESP_LSB];
        end else begin : g_exokay_map
            assign push_bresp = map_exokay(bus.resp[RESP_BRESP_MSB:RESP_BRESP_LSB]);
        end
    endgenerate

    assign push_data = {push_id, push_bresp};

    assign b_valid = !fifo_empty;
    assign b_pop   = b_valid && bus.m_bready;

    // Drop only when there is truly no room: full and the head is not leaving.
    assign drop = bus.resp_valid && fifo_full && !b_pop;

    b_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .arst_n    (arst_n),
        .push      (bus.resp_valid),
        .push_data (push_data),
        .pop       (b_pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // B-channel outputs come straight from the FIFO head; held at zero while empty
    // so the outputs show clean values during and right after reset.
    always_comb begin
        bus.m_bvalid = b_valid;
        bus.m_bid    = '0;
        bus.m_bresp  = '0;
        if (b_valid) begin
            bus.m_bid   = head_data[ENTRY_W-1:BRESP_WIDTH];
            bus.m_bresp = head_data[BRESP_WIDTH-1:0];
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_b_resp_return.sv
// Bench for b_resp_return: two instances (EXOKAY mapped / passed through) share
// one stimulus stream and are compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_b_resp_return;
    localparam int DEPTH = 8;

    logic       aclk = 1'b0;
    logic       arst_n;
    logic       resp_valid;
    logic [8:0] resp;
    logic       m_bready;

    logic [3:0] lvl0, lvl1;
    logic       ovf0, ovf1;
    logic [7:0] dc0, dc1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of {id, raw bresp}, sticky overflow, drop count.
    logic [4:0] q[$];
    logic       m_ovf;
    int         m_drops;

    always #5 aclk = ~aclk;

    b_resp_return_if #(.BID_WIDTH(3), .BRESP_WIDTH(2), .RESP_ARR_WIDTH(9)) bus0 ();
    b_resp_return_if #(.BID_WIDTH(3), .BRESP_WIDTH(2), .RESP_ARR_WIDTH(9)) bus1 ();

    assign bus0.resp_valid = resp_valid;
    assign bus0.resp       = resp;
    assign bus0.m_bready   = m_bready;
    assign bus1.resp_valid = resp_valid;
    assign bus1.resp       = resp;
    assign bus1.m_bready   = m_bready;

    b_resp_return #(.BID_WIDTH(3), .BRESP_WIDTH(2), .RESP_ARR_WIDTH(9),
                    .DEPTH(DEPTH), .EXOKAY_PASS(1'b0)) dut0 (
        .aclk(aclk), .arst_n(arst_n), .bus(bus0),
        .fifo_level(lvl0), .overflow(ovf0), .drop_cnt(dc0));

    b_resp_return #(.BID_WIDTH(3), .BRESP_WIDTH(2), .RESP_ARR_WIDTH(9),
                    .DEPTH(DEPTH), .EXOKAY_PASS(1'b1)) dut1 (
        .aclk(aclk), .arst_n(arst_n), .bus(bus1),
        .fifo_level(lvl1), .overflow(ovf1), .drop_cnt(dc1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input int id, input int cnt, input int br);
        logic [8:0] r;
        r = {1'b0, id[2:0], cnt[2:0], br[1:0]};
        return r;
    endfunction

    function automatic logic [1:0] exp_mapped(input logic [1:0] raw);
        return (raw == 2'b01) ? 2'b00 : raw;
    endfunction

    // Compare both instances against the model state.
    task automatic check_outputs(input string tag);
        logic [4:0] head;
        int         exp_drops;
        exp_drops = (m_drops > 255) ? 255 : m_drops;
        check({tag, " bvalid0"}, 32'(bus0.m_bvalid), 32'(q.size() != 0));
        check({tag, " bvalid1"}, 32'(bus1.m_bvalid), 32'(q.size() != 0));
        check({tag, " level0"}, 32'(lvl0), 32'(q.size()));
        check({tag, " level1"}, 32'(lvl1), 32'(q.size()));
        check({tag, " ovf0"}, 32'(ovf0), 32'(m_ovf));
        check({tag, " ovf1"}, 32'(ovf1), 32'(m_ovf));
        check({tag, " drop0"}, 32'(dc0), 32'(exp_drops));
        check({tag, " drop1"}, 32'(dc1), 32'(exp_drops));
        if (q.size() != 0) begin
            head = q[0];
            check({tag, " bid0"}, 32'(bus0.m_bid), 32'(head[4:2]));
            check({tag, " bid1"}, 32'(bus1.m_bid), 32'(head[4:2]));
            check({tag, " bresp0"}, 32'(bus0.m_bresp), 32'(exp_mapped(head[1:0])));
            check({tag, " bresp1"}, 32'(bus1.m_bresp), 32'(head[1:0]));
        end
    endtask

    // Everything reads zero while reset is applied.
    task automatic check_reset(input string tag);
        check({tag, " bvalid0"}, 32'(bus0.m_bvalid), 32'd0);
        check({tag, " bvalid1"}, 32'(bus1.m_bvalid), 32'd0);
        check({tag, " bid0"}, 32'(bus0.m_bid), 32'd0);
        check({tag, " bresp0"}, 32'(bus0.m_bresp), 32'd0);
        check({tag, " bid1"}, 32'(bus1.m_bid), 32'd0);
        check({tag, " bresp1"}, 32'(bus1.m_bresp), 32'd0);
        check({tag, " level0"}, 32'(lvl0), 32'd0);
        check({tag, " level1"}, 32'(lvl1), 32'd0);
        check({tag, " ovf0"}, 32'(ovf0), 32'd0);
        check({tag, " ovf1"}, 32'(ovf1), 32'd0);
        check({tag, " drop0"}, 32'(dc0), 32'd0);
        check({tag, " drop1"}, 32'(dc1), 32'd0);
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge,
    // sample 1 ns later.
    task automatic step(input string tag, input logic rv, input logic [8:0] r, input logic rdy);
        bit do_pop;
        @(negedge aclk);
        resp_valid = rv;
        resp       = r;
        m_bready   = rdy;
        @(posedge aclk);
        do_pop = (q.size() != 0) && rdy;
        if (do_pop) begin
            void'(q.pop_front());
        end
        if (rv) begin
            if (q.size() < DEPTH) begin
                q.push_back({r[7:5], r[1:0]});
            end else begin
                m_ovf = 1'b1;
                m_drops++;
            end
        end
        #1;
        check_outputs(tag);
        $display("[TB] %s rv=%0b resp=%03h rdy=%0b -> level=%0d bvalid=%0b bid=%0d bresp0=%0d bresp1=%0d ovf=%0b drops=%0d",
                 tag, rv, r, rdy, lvl0, bus0.m_bvalid, bus0.m_bid, bus0.m_bresp, bus1.m_bresp, ovf0, dc0);
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge aclk);
        resp_valid = 1'b0;
        m_bready   = 1'b0;
        arst_n     = 1'b0;
        model_clear();
        #1;
        check_reset(tag);
        @(negedge aclk);
        arst_n = 1'b1;
    endtask

    task automatic idle(input string tag, input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, 9'h000, rdy);
        end
    endtask

    initial begin
        arst_n     = 1'b0;
        resp_valid = 1'b0;
        resp       = '0;
        m_bready   = 1'b0;
        model_clear();
        #12;
        check_reset("reset");
        @(negedge aclk);
        arst_n = 1'b1;

        // T1 single response
        step("T1 push", 1'b1, mk(5, 0, 0), 1'b1);
        step("T1 hs", 1'b0, 9'h000, 1'b1);
        idle("T1 idle", 1, 1'b1);

        // T2 back-pressure and ordering
        step("T2 push1", 1'b1, mk(1, 2, 0), 1'b0);
        step("T2 push2", 1'b1, mk(2, 1, 2), 1'b0);
        step("T2 push3", 1'b1, mk(3, 7, 3), 1'b0);
        idle("T2 hold", 3, 1'b0);
        idle("T2 drain", 4, 1'b1);

        // T3 full then one dropped push
        for (int i = 0; i < DEPTH; i++) begin
            step("T3 fill", 1'b1, mk(i, i, i % 4), 1'b0);
        end
        step("T3 drop", 1'b1, mk(7, 0, 2), 1'b0);
        idle("T3 drain", DEPTH + 1, 1'b1);

        // T4 full with simultaneous push and pop
        do_reset("T4 reset");
        for (int i = 0; i < DEPTH; i++) begin
            step("T4 fill", 1'b1, mk(i % 6, 0, 3 - (i % 4)), 1'b0);
        end
        step("T4 pushpop", 1'b1, mk(6, 0, 2), 1'b1);
        idle("T4 drain", DEPTH + 1, 1'b1);

        // T5 EXOKAY mapping (instance 0 maps, instance 1 passes)
        step("T5 exokay", 1'b1, mk(4, 1, 1), 1'b0);
        idle("T5 drain", 2, 1'b1);

        // T6 reset in the middle of a drain
        for (int i = 0; i < 4; i++) begin
            step("T6 fill", 1'b1, mk(i + 2, 0, 2), 1'b0);
        end
        step("T6 drain", 1'b0, 9'h000, 1'b1);
        #2;
        arst_n = 1'b0;
        model_clear();
        #1;
        check_reset("T6 async");
        @(negedge aclk);
        @(negedge aclk);
        arst_n = 1'b1;
        step("T6 push", 1'b1, mk(3, 0, 1), 1'b1);
        idle("T6 drain", 2, 1'b1);

        // Drop counter saturation
        do_reset("sat reset");
        for (int i = 0; i < DEPTH + 262; i++) begin
            step("sat", 1'b1, 9'($urandom), 1'b0);
        end
        idle("sat drain", DEPTH + 1, 1'b1);

        // Randomized traffic against the model
        do_reset("rand reset");
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) < 6), 9'($urandom), 1'($urandom_range(0, 1)));
        end
        idle("rand drain", DEPTH + 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
